cmos_dvp_tx: RTL and testbench

CMOS_DVP_TX -- requirements
Module: cmos_dvp_tx

---
 rtl/cmos_dvp_tx_if.sv | 19 +
 rtl/cmos_dvp_tx.sv | 177 +++++++++++++++++
 tb/tb_cmos_dvp_tx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_dvp_tx_if.sv
// Pixel stream into the DVP transmitter.
// The source drives s_data/s_valid, and the transmitter answers with s_ready.
interface cmos_dvp_tx_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/cmos_dvp_tx.sv
// CMOS DVP frame transmitter.
// It generates vsync/href timing from an external stream or a test pattern.
module cmos_dvp_tx #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 160,
    parameter int V_ACTIVE  = 360,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 8,
    parameter int V_FRONT   = 4
) (
    input  logic         cmos_pclk,
    input  logic         sys_rst_n,
    input  logic         enable,
    input  logic [1:0]   pattern_sel,
    cmos_dvp_tx_if.slave s,
    output logic         cmos_vsync,
    output logic         cmos_href,
    output logic [15:0]  cmos_data,
    output logic         frame_done,
    output logic         underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int V_M1    = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
    localparam int V_M2    = (VSYNC_LEN > V_FRONT) ? VSYNC_LEN : V_FRONT;
    localparam int V_MAX   = (V_M1 > V_M2) ? V_M1 : V_M2;
    localparam int VW      = $clog2(V_MAX + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);
    localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LEN - 1);
    localparam logic [VW-1:0] VB_LAST  = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VF_LAST  = VW'(V_FRONT - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        VFP
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [VW-1:0] v_last;
    logic [HW-1:0] bar_px_q, bar_px_d;
    logic [2:0]    bar_q, bar_d;
    logic [1:0]    pat_q;
    logic          vsync_q, href_q, done_q, uflow_q;
    logic [15:0]   data_q;

    logic          href_d;
    logic          ready;
    logic          entering;
    logic          chk;
    logic [15:0]   x_ext;
    logic [15:0]   bar_rgb;
    logic [15:0]   pix;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        unique case (state_q)
            VSYNC:   v_last = VS_LAST;
            VBP:     v_last = VB_LAST;
            ACTIVE:  v_last = VA_LAST;
            VFP:     v_last = VF_LAST;
            default: v_last = '0;
        endcase
        if (state_q == IDLE) begin
            h_d = '0;
            v_d = '0;
            if (enable) state_d = VSYNC;
        end else if (h_q != H_LAST) begin
            h_d = h_q + 1'b1;
        end else begin
            h_d = '0;
            if (v_q != v_last) begin
                v_d = v_q + 1'b1;
            end else begin
                v_d = '0;
                unique case (state_q)
                    VSYNC:   state_d = VBP;
                    VBP:     state_d = ACTIVE;
                    ACTIVE:  state_d = VFP;
                    VFP:     state_d = enable ? VSYNC : IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Bar position tracks the pixel being loaded, so no divider is needed.
    always_comb begin
        href_d   = (state_d == ACTIVE) && (h_d < H_ACT);
        bar_px_d = bar_px_q;
        bar_d    = bar_q;
        if (href_d) begin
            if (h_d == '0) begin
                bar_px_d = '0;
                bar_d    = '0;
            end else if (bar_px_q == BAR_LAST) begin
                bar_px_d = '0;
                bar_d    = bar_q + 1'b1;
            end else begin
                bar_px_d = bar_px_q + 1'b1;
            end
        end
    end

    always_comb begin
        x_ext = 16'(h_d);
        chk   = x_ext[4] ^ (|(16'(v_d) & 16'h0010));
        unique case (bar_d)
            3'd0: bar_rgb = 16'hFFFF;
            3'd1: bar_rgb = 16'hFFE0;
            3'd2: bar_rgb = 16'h07FF;
            3'd3: bar_rgb = 16'h07E0;
            3'd4: bar_rgb = 16'hF81F;
            3'd5: bar_rgb = 16'hF800;
            3'd6: bar_rgb = 16'h001F;
            3'd7: bar_rgb = 16'h0000;
        endcase
        unique case (pat_q)
            2'd0: pix = s.s_valid ? s.s_data : 16'h0000;
            2'd1: pix = bar_rgb;
            2'd2: pix = x_ext;
            2'd3: pix = chk ? 16'hFFFF : 16'h0000;
        endcase
    end

    assign ready     = sys_rst_n && href_d && (pat_q == 2'd0);
    assign s.s_ready = ready;
    assign entering  = (state_d == VSYNC) && (state_q != VSYNC);

    always_ff @(posedge cmos_pclk) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            h_q      <= '0;
            v_q      <= '0;
            bar_px_q <= '0;
            bar_q    <= '0;
            pat_q    <= '0;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            bar_px_q <= bar_px_d;
            bar_q    <= bar_d;
            if (entering) pat_q <= pattern_sel;
            vsync_q  <= (state_d == VSYNC);
            href_q   <= href_d;
            data_q   <= href_d ? pix : 16'h0000;
            done_q   <= (state_d == VFP) && (h_d == H_LAST) &&
                        (v_d == VF_LAST);
            uflow_q  <= entering ? 1'b0 :
                        (uflow_q | (ready & ~s.s_valid));
        end
    end

    assign cmos_vsync = vsync_q;
    assign cmos_href  = href_q;
    assign cmos_data  = data_q;
    assign frame_done = done_q;
    assign underflow  = uflow_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Bench for cmos_dvp_tx: a frame-level reference model checked every cycle,
// plus table-driven scenario rows and hand-written corner sequences.
module tb_cmos_dvp_tx;

    localparam int HA = 64;
    localparam int HB = 16;
    localparam int VA = 36;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VF = 2;
    localparam int HT = HA + HB;
    localparam int LINES = VS + VB + VA + VF;
    localparam int FRAME = LINES * HT;
    localparam int ACT0 = (VS + VB) * HT;
    localparam logic [15:0] BARS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        vsync, href, fd, uf;
    logic [15:0] data;

    cmos_dvp_tx_if sif ();

    cmos_dvp_tx #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .VSYNC_LEN(VS),
        .V_BACK   (VB),
        .V_FRONT  (VF)
    ) dut (
        .cmos_pclk  (clk),
        .sys_rst_n  (rst_n),
        .enable     (en),
        .pattern_sel(sel),
        .s          (sif.slave),
        .cmos_vsync (vsync),
        .cmos_href  (href),
        .cmos_data  (data),
        .frame_done (fd),
        .underflow  (uf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          m_t = -1;
    logic [1:0]  m_pat = 2'd0;
    logic [15:0] m_pend = 16'h0;
    bit          m_uf = 1'b0;
    int          vmode = 0;
    int          drop_t = -1;
    logic [15:0] inc = 16'h0;
    int          n_fd = 0, n_rise = 0, n_vrise = 0;
    bit          prev_href = 1'b0, prev_vs = 1'b0;

    typedef struct {
        bit         rst_n;
        bit         en;
        logic [1:0] sel;
        int         vmode;
        int         cycles;
        int         e_fd;
        int         e_rise;
        bit         e_uf;
    } row_t;

    row_t rows [9];

    function automatic bit f_href(int t);
        int y;
        if (t < 0 || t >= FRAME) return 1'b0;
        y = t / HT - VS - VB;
        return (y >= 0) && (y < VA) && (t % HT < HA);
    endfunction

    function automatic bit f_vs(int t);
        return (t >= 0) && (t < VS * HT);
    endfunction

    function automatic logic [15:0] f_pix(logic [1:0] p, int t);
        int x, y;
        x = t % HT;
        y = t / HT - VS - VB;
        case (p)
            2'd1:    return BARS[x / (HA / 8)];
            2'd2:    return 16'(x);
            2'd3:    return ((x / 16 + y / 16) % 2 == 1) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit f_rdy();
        return rst_n && (m_t >= 0) && (m_pat == 2'd0) && f_href(m_t + 1);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, m_t, got, exp);
        end
    endtask

    task automatic tick();
        bit          rdy;
        logic [20:0] e, g;
        case (vmode)
            0: begin
                sif.s_valid = 1'b1;
                sif.s_data  = inc;
            end
            1: begin
                sif.s_valid = ($urandom_range(0, 3) != 0);
                sif.s_data  = 16'($urandom);
            end
            default: begin
                sif.s_valid = (m_t != drop_t);
                sif.s_data  = inc;
            end
        endcase
        rdy = f_rdy();
        if (rdy) begin
            m_pend = sif.s_valid ? sif.s_data : 16'h0000;
            if (!sif.s_valid) m_uf = 1'b1;
            else inc++;
        end
        if (!rst_n) begin
            m_t  = -1;
            m_uf = 1'b0;
        end else if (m_t == -1 || m_t == FRAME - 1) begin
            if (en) begin
                m_t   = 0;
                m_pat = sel;
                m_uf  = 1'b0;
            end else begin
                m_t = -1;
            end
        end else begin
            m_t++;
        end
        @(posedge clk);
        #1;
        e = {f_vs(m_t), f_href(m_t), (m_t == FRAME - 1), m_uf, f_rdy(),
             f_href(m_t) ? ((m_pat == 2'd0) ? m_pend : f_pix(m_pat, m_t))
                         : 16'h0000};
        g = {vsync, href, fd, uf, sif.s_ready, data};
        check("cycle", 32'(g), 32'(e));
        if (fd) n_fd++;
        if (href && !prev_href) n_rise++;
        if (vsync && !prev_vs) n_vrise++;
        prev_href = href;
        prev_vs   = vsync;
    endtask

    initial begin
        rows[0] = '{1'b0, 1'b0, 2'd0, 0, 5,     0, 0,  1'b0};
        rows[1] = '{1'b1, 1'b1, 2'd1, 0, FRAME, 1, VA, 1'b0};
        rows[2] = '{1'b1, 1'b1, 2'd2, 0, FRAME, 1, VA, 1'b0};
        rows[3] = '{1'b1, 1'b1, 2'd3, 0, FRAME, 1, VA, 1'b0};
        rows[4] = '{1'b1, 1'b1, 2'd0, 0, FRAME, 1, VA, 1'b0};
        rows[5] = '{1'b1, 1'b1, 2'd0, 1, FRAME, 1, VA, 1'b1};
        rows[6] = '{1'b1, 1'b0, 2'd1, 0, 200,   0, 0,  1'b1};
        rows[7] = '{1'b1, 1'b1, 2'd1, 0, FRAME, 1, VA, 1'b0};
        rows[8] = '{1'b1, 1'b0, 2'd0, 0, 100,   0, 0,  1'b0};
        sif.s_valid = 1'b0;
        sif.s_data  = 16'h0;

        for (int i = 0; i < 9; i++) begin
            rst_n  = rows[i].rst_n;
            en     = rows[i].en;
            sel    = rows[i].sel;
            vmode  = rows[i].vmode;
            n_fd   = 0;
            n_rise = 0;
            repeat (rows[i].cycles) tick();
            check($sformatf("row%0d frame_done", i), 32'(n_fd), 32'(rows[i].e_fd));
            check($sformatf("row%0d href_lines", i), 32'(n_rise), 32'(rows[i].e_rise));
            check($sformatf("row%0d underflow", i), 32'(uf), 32'(rows[i].e_uf));
        end

        // starved pixel at x=10 of the first active line
        vmode  = 2;
        drop_t = ACT0 + 9;
        en     = 1'b1;
        sel    = 2'd0;
        n_rise = 0;
        repeat (ACT0 + 11) tick();
        check("x10 data", 32'(data), 32'h0);
        check("x10 underflow", 32'(uf), 32'h1);
        repeat (FRAME - 1 - (ACT0 + 10)) tick();
        check("uf held", 32'(uf), 32'h1);
        check("uf href_lines", 32'(n_rise), 32'(VA));
        tick();
        check("uf cleared", 32'(uf), 32'h0);
        check("uf new vsync", 32'(vsync), 32'h1);
        en    = 1'b0;
        vmode = 0;
        repeat (FRAME) tick();

        // pattern and enable changed mid-frame
        en    = 1'b1;
        sel   = 2'd1;
        n_fd  = 0;
        repeat (ACT0 + 1) tick();
        check("bar px0", 32'(data), 32'hFFFF);
        repeat (8) tick();
        check("bar px8", 32'(data), 32'hFFE0);
        repeat (55) tick();
        check("bar px63", 32'(data), 32'h0000);
        repeat (10 * HT + 5 - 64) tick();
        sel = 2'd3;
        en  = 1'b0;
        repeat (FRAME - (ACT0 + 10 * HT + 5)) tick();
        n_vrise = 0;
        repeat (300) tick();
        check("midchg frame_done", 32'(n_fd), 32'h1);
        check("midchg no vsync", 32'(n_vrise), 32'h0);

        // reset during an active line
        en   = 1'b1;
        sel  = 2'd2;
        n_fd = 0;
        repeat (ACT0 + 5 * HT + 21) tick();
        rst_n = 1'b0;
        tick();
        check("rst outputs", 32'({vsync, href, fd, uf, data}), 32'h0);
        check("rst no frame_done", 32'(n_fd), 32'h0);
        rst_n  = 1'b1;
        n_rise = 0;
        repeat (FRAME) tick();
        check("rst refr frame_done", 32'(n_fd), 32'h1);
        check("rst refr href_lines", 32'(n_rise), 32'(VA));
        en = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
